// File: rtl/bd_upstream_packer.sv
// bd_upstream_packer: splits BD upstream words into LO/HI PC words for the pipe-out channel and
// pads partial pipe blocks with NOP words. Define BD_UPSTREAM_PACKER_STATS_EN for stat counters.
module bd_upstream_packer #(
    parameter int unsigned NBDout         = 34,
    parameter int unsigned NPCcode        = 8,
    parameter int unsigned NPCdata        = 24,
    parameter int unsigned NOPcode        = 64,
    parameter int unsigned LOcode         = 65,
    parameter int unsigned HIcode         = 66,
    parameter int unsigned BLOCK_WORDS    = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NBDout-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NPCcode+NPCdata-1:0] out_data
`ifdef BD_UPSTREAM_PACKER_STATS_EN
    ,
    output logic [31:0]                stat_words,
    output logic [31:0]                stat_pads
`endif
);

    localparam int unsigned HiW   = NBDout - NPCdata;
    localparam int unsigned CntW  = $clog2(BLOCK_WORDS);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned OutW  = NPCcode + NPCdata;

    localparam logic [NPCcode-1:0] NopCode = NPCcode'(NOPcode);
    localparam logic [NPCcode-1:0] LoCode  = NPCcode'(LOcode);
    localparam logic [NPCcode-1:0] HiCode  = NPCcode'(HIcode);
    localparam logic [CntW-1:0]    CntLast = CntW'(BLOCK_WORDS - 1);
    localparam logic [IdleW-1:0]   IdleMax = IdleW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_LO, S_HI, S_PAD} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   word_cnt_q, word_cnt_d;
    logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
    logic [HiW-1:0]    hi_hold_q, hi_hold_d;
    logic              out_valid_q, out_valid_d;
    logic [OutW-1:0]   out_data_q, out_data_d, load_data;
    logic              slot_free, pad_trigger, accept, load;

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
        pad_trigger = (state_q == S_LO) && (word_cnt_q != '0) && (idle_cnt_q == IdleMax);
        // Gated by reset so the handshake reads as not-ready while held in reset.
        in_ready    = !reset && (state_q == S_LO) && slot_free && !pad_trigger;
        accept      = in_valid && in_ready;

        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        hi_hold_d   = hi_hold_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        load        = 1'b0;
        load_data   = '0;

        unique case (state_q)
            S_LO: begin
                if (accept) begin
                    load       = 1'b1;
                    load_data  = {LoCode, in_data[NPCdata-1:0]};
                    hi_hold_d  = in_data[NBDout-1:NPCdata];
                    idle_cnt_d = '0;
                    state_d    = S_HI;
                end else if (pad_trigger) begin
                    state_d = S_PAD;
                end else if (word_cnt_q == '0) begin
                    idle_cnt_d = '0;
                end else if (!in_valid && (idle_cnt_q != IdleMax)) begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
            S_HI: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = {HiCode, NPCdata'(hi_hold_q)};
                    state_d   = S_LO;
                end
            end
            S_PAD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = {NopCode, {NPCdata{1'b0}}};
                    // The pad that fills the last slot of the block ends the sequence.
                    if (word_cnt_q == CntLast) begin
                        state_d    = S_LO;
                        idle_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_LO;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
            word_cnt_d  = word_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_LO;
            word_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            hi_hold_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            hi_hold_q   <= hi_hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef BD_UPSTREAM_PACKER_STATS_EN
    logic [31:0] stat_words_q, stat_pads_q;
    logic        pad_load;

    assign pad_load = load && (state_q == S_PAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_words_q <= '0;
            stat_pads_q  <= '0;
        end else begin
            if (accept) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (pad_load) begin
                stat_pads_q <= stat_pads_q + 32'd1;
            end
        end
    end

    assign stat_words = stat_words_q;
    assign stat_pads  = stat_pads_q;
`endif

endmodule

// File: tb/tb_bd_upstream_packer.sv
// tb_bd_upstream_packer: directed scenarios plus randomized traffic checked against a
// queue-based model of the LO/HI split and block padding rules.
module tb_bd_upstream_packer;

    localparam int unsigned BW    = 256;
    localparam int unsigned TO    = 4;
    localparam logic [7:0]  LO_C  = 8'h41;
    localparam logic [7:0]  HI_C  = 8'h42;
    localparam logic [31:0] NOP_W = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef BD_UPSTREAM_PACKER_STATS_EN
    logic [31:0] stat_words, stat_pads;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;

    // Model state: words owed to the output in order, position within the current block.
    logic [31:0] exp_q[$];
    int          blk_pos;
    bit          padding, prev_stall, mon_pad;
    logic [31:0] prev_data;
    int          acc_cnt, pad_cnt;

    logic [33:0] w, w2;
    logic [31:0] seen0, seen1, first_w;
    int          gap, pads, acc_at, n_sent, n_out, gaps, bad_code, sent, nseen;
    bit          acc, started, got_data, done, any_valid;

    always #5 clk = ~clk;

    bd_upstream_packer #(
        .BLOCK_WORDS   (BW),
        .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BD_UPSTREAM_PACKER_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_pads (stat_pads)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] rand34();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[33:0];
    endfunction

    function automatic logic [31:0] lo_word(input logic [33:0] d);
        return {LO_C, d[23:0]};
    endfunction

    function automatic logic [31:0] hi_word(input logic [33:0] d);
        return {HI_C, 14'h0, d[33:24]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            blk_pos    = 0;
            padding    = 0;
            prev_stall = 0;
            acc_cnt    = 0;
            pad_cnt    = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            // Two owed words means the HI half has not been loaded yet.
            if (exp_q.size() >= 2) check("hi_pending_ready", in_ready, 0);
            if (padding && (BW - blk_pos) >= 2) check("pad_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                mon_pad = (exp_q.size() == 0);
                if (mon_pad) begin
                    check("pad_word", out_data, NOP_W);
                    check("pad_mid_block", blk_pos != 0, 1);
                    pad_cnt++;
                end else begin
                    check("data_word", out_data, exp_q.pop_front());
                end
                blk_pos = (blk_pos + 1) % BW;
                padding = mon_pad && (blk_pos != 0);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(lo_word(in_data));
                exp_q.push_back(hi_word(in_data));
                acc_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #7;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);

        // Single word, then idle timeout pads the rest of the block.
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 34'h2_ABCD_1234;
        @(negedge clk);
        check("t1_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lo", out_data, 32'h41CD_1234);
        @(negedge clk);
        // Bits [33:24] of 34'h2_ABCD_1234 are 10'h2AB.
        check("t1_hi", out_data, 32'h4200_02AB);
        gap = 0;
        @(negedge clk);
        while (!out_valid && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        check("t1_gap", gap, TO);
        pads = 0;
        while (out_valid && out_data == NOP_W && pads < 300) begin
            pads++;
            @(negedge clk);
        end
        check("t1_pads", pads, 254);
        check("t1_after", out_valid, 0);

        // 128 back-to-back words fill one block exactly.
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = rand34();
        n_sent = 0; n_out = 0; gaps = 0; bad_code = 0; started = 0;
        for (int c = 0; c < 600 && n_out < 256; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                started = 1;
                if (out_data[31:24] != ((n_out % 2 == 0) ? LO_C : HI_C)) bad_code++;
                n_out++;
            end else if (started) begin
                gaps++;
            end
            if (acc) n_sent++;
            @(posedge clk); #1;
            if (acc) begin
                if (n_sent == 128) in_valid = 1'b0;
                else in_data = rand34();
            end
        end
        check("t2_out_count", n_out, 256);
        check("t2_sent", n_sent, 128);
        check("t2_gaps", gaps, 0);
        check("t2_codes", bad_code, 0);
        any_valid = 0;
        repeat (3 * TO) begin
            @(negedge clk);
            if (out_valid) any_valid = 1;
        end
        check("t2_no_pad", any_valid, 0);

        // Output stall after a LO load.
        do_reset();
        @(posedge clk); #1;
        w        = rand34();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        check("t3_accept", in_ready, 1);
        @(posedge clk); #1;
        w2      = rand34();
        in_data = w2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_data", out_data, lo_word(w));
            check("t3_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_lo_release", out_data, lo_word(w));
        @(negedge clk);
        check("t3_hi", out_data, hi_word(w));
        check("t3_w2_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Input arrives on the pad_trigger cycle: padding wins.
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        w        = rand34();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        check("t4_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_hi", out_data, hi_word(w));
        repeat (TO - 1) @(posedge clk);
        #1;
        w2       = rand34();
        in_valid = 1'b1;
        in_data  = w2;
        @(negedge clk);
        check("t4_race_ready", in_ready, 0);
        pads = 0; acc_at = -1; got_data = 0; first_w = '0;
        for (int c = 0; c < 400 && !got_data; c++) begin
            @(negedge clk);
            if (out_valid && out_data == NOP_W) pads++;
            else if (out_valid) begin
                got_data = 1;
                first_w  = out_data;
            end
            if (in_valid && in_ready) acc_at = pads;
            if (!got_data) begin
                @(posedge clk); #1;
                if (acc_at >= 0) in_valid = 1'b0;
            end
        end
        check("t4_pads", pads, 254);
        check("t4_accept_after_pads", acc_at, 254);
        check("t4_first_data", first_w, lo_word(w2));
        in_valid = 1'b0;

        // Reset between LO and HI discards the pair.
        do_reset();
        @(posedge clk); #1;
        w        = rand34();
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        check("t5_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_lo", out_data, lo_word(w));
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_ready", in_ready, 0);
        @(negedge clk); #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        w2       = rand34();
        in_valid = 1'b1;
        in_data  = w2;
        nseen = 0; seen0 = '0; seen1 = '0;
        for (int c = 0; c < 20 && nseen < 2; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (nseen == 0) seen0 = out_data;
                else seen1 = out_data;
                nseen++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        check("t5_first", seen0, lo_word(w2));
        check("t5_second", seen1, hi_word(w2));

`ifdef BD_UPSTREAM_PACKER_STATS_EN
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = rand34();
        sent = 0;
        for (int c = 0; c < 20 && sent < 3; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            if (acc) begin
                if (sent == 3) in_valid = 1'b0;
                else in_data = rand34();
            end
        end
        repeat (300) @(negedge clk);
        check("stats_words", stat_words, 3);
        check("stats_pads", stat_pads, 250);
`endif

        // Randomized traffic with backpressure, busy phase then sparse phase.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 9) < ((c < 2000) ? 8 : 3));
                in_data  = rand34();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && blk_pos == 0 && !out_valid) done = 1;
        end
        check("drain_done", done, 1);
        repeat (2 * TO) @(negedge clk);
        check("drain_quiet", out_valid, 0);
`ifdef BD_UPSTREAM_PACKER_STATS_EN
        check("rand_stat_words", stat_words, acc_cnt);
        check("rand_stat_pads", stat_pads, pad_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
